// File: rtl/servant_gpio_xchg.sv
// Neighbour-exchange stage: gathers own + up to 8 neighbour words per generation, then strobes them
// into the servant GPIO input side. Optional collect timeout under `SERVANT_XCHG_TIMEOUT_EN`.
module servant_gpio_xchg #(
  parameter logic [7:0]  NBR_MASK = 8'hFF,
  parameter int unsigned TIMEOUT  = 1000,
  parameter int unsigned GEN_W    = 16
) (
  input  logic             i_wb_clk,
  input  logic             i_wb_rst_n,
  input  logic             i_local_clk,
  input  logic [31:0]      i_local_dat,
  input  logic [7:0]       i_nbr_clk,
  input  logic [255:0]     i_nbr_dat,
  input  logic             i_hold,
  output logic             o_gpio_in_clk,
  output logic [31:0]      o_gpio_in,
  output logic [31:0]      o_gpio_in_n,
  output logic [31:0]      o_gpio_in_ne,
  output logic [31:0]      o_gpio_in_e,
  output logic [31:0]      o_gpio_in_se,
  output logic [31:0]      o_gpio_in_s,
  output logic [31:0]      o_gpio_in_sw,
  output logic [31:0]      o_gpio_in_w,
  output logic [31:0]      o_gpio_in_nw,
  output logic [GEN_W-1:0] o_gen,
  output logic             o_overrun,
  output logic             o_timeout
);

  typedef enum logic [1:0] {StIdle, StCollect, StDeliver} state_e;

  state_e             r_state, w_state_d;
  logic [31:0]        r_cap [8];
  logic [7:0]         r_flag;
  logic [31:0]        r_cap_local;
  logic               r_lflag;
  logic [31:0]        r_dout [9];
  logic [GEN_W-1:0]   r_gen;
  logic               r_overrun;

  logic [7:0]         w_nbr_stb;
  logic               w_ready;
  logic               w_clear;
  logic               w_load;
  logic               w_tmo_hit;

  assign w_nbr_stb = i_nbr_clk & NBR_MASK;
  assign w_ready   = r_lflag & (&(r_flag | ~NBR_MASK));
  assign w_clear   = (r_state == StDeliver) & ~i_hold;
  assign w_load    = (r_state != StDeliver) && (w_state_d == StDeliver);

`ifdef SERVANT_XCHG_TIMEOUT_EN
  logic [31:0] r_tmo_cnt;
  logic        r_timeout;

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      r_tmo_cnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_tmo_cnt <= (r_state == StCollect) ? r_tmo_cnt + 32'd1 : '0;
      if (w_tmo_hit && !w_ready) r_timeout <= 1'b1;
    end
  end

  assign w_tmo_hit = (r_state == StCollect) && (r_tmo_cnt == 32'(TIMEOUT - 1));
  assign o_timeout = r_timeout;
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = 32'(TIMEOUT);
  assign w_tmo_hit        = 1'b0;
  assign o_timeout        = 1'b0;
`endif

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) r_state <= StIdle;
    else             r_state <= w_state_d;
  end

  // A generation that is already complete in IDLE skips COLLECT to keep the 2-cycle latency.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:    if (r_lflag) w_state_d = w_ready ? StDeliver : StCollect;
      StCollect: if (w_ready || w_tmo_hit) w_state_d = StDeliver;
      StDeliver: if (!i_hold) w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  always_comb begin
    o_gpio_in_clk = 1'b0;
    if (r_state == StDeliver) o_gpio_in_clk = ~i_hold;
  end

  // A strobe in the clearing cycle starts the next generation instead of counting as an overrun.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      for (int k = 0; k < 8; k++) r_cap[k] <= '0;
      r_flag      <= '0;
      r_cap_local <= '0;
      r_lflag     <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (w_nbr_stb[k] && (!r_flag[k] || w_clear)) begin
          r_cap[k]  <= i_nbr_dat[32*k +: 32];
          r_flag[k] <= 1'b1;
        end else if (w_clear) begin
          r_flag[k] <= 1'b0;
        end
      end
      if (|(w_nbr_stb & r_flag) && !w_clear) r_overrun <= 1'b1;
      if (i_local_clk) begin
        r_cap_local <= i_local_dat;
        r_lflag     <= 1'b1;
      end else if (w_clear) begin
        r_lflag     <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      for (int k = 0; k < 9; k++) r_dout[k] <= '0;
      r_gen <= '0;
    end else begin
      if (w_load) begin
        r_dout[0] <= r_cap_local;
        for (int k = 0; k < 8; k++) r_dout[k+1] <= NBR_MASK[k] ? r_cap[k] : 32'd0;
      end
      if (w_clear) r_gen <= r_gen + 1'b1;
    end
  end

  assign o_gpio_in    = r_dout[0];
  assign o_gpio_in_n  = r_dout[1];
  assign o_gpio_in_ne = r_dout[2];
  assign o_gpio_in_e  = r_dout[3];
  assign o_gpio_in_se = r_dout[4];
  assign o_gpio_in_s  = r_dout[5];
  assign o_gpio_in_sw = r_dout[6];
  assign o_gpio_in_w  = r_dout[7];
  assign o_gpio_in_nw = r_dout[8];
  assign o_gen        = r_gen;
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_servant_gpio_xchg.sv
// Directed bench for servant_gpio_xchg: full mesh, partial mask and (when SERVANT_XCHG_TIMEOUT_EN
// is defined) timeout instances share one stimulus stream.
module tb_servant_gpio_xchg;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         local_clk = 1'b0;
  logic [31:0]  local_dat = '0;
  logic [7:0]   nbr_clk = '0;
  logic [255:0] nbr_dat = '0;
  logic         hold = 1'b0;

  logic [2:0]        stb;
  logic [8:0][31:0]  w0, w1, w2;
  logic [15:0]       gen0, gen1, gen2;
  logic [2:0]        ovr, tmo;

  int n_checks = 0;
  int n_err    = 0;
  int pulses   = 0;
  int dbl      = 0;
  logic prev_stb = 1'b0;

  always #5 clk = ~clk;

  servant_gpio_xchg #(.NBR_MASK(8'hFF), .TIMEOUT(1000), .GEN_W(16)) u_dut (
    .i_wb_clk(clk), .i_wb_rst_n(rst_n), .i_local_clk(local_clk), .i_local_dat(local_dat),
    .i_nbr_clk(nbr_clk), .i_nbr_dat(nbr_dat), .i_hold(hold), .o_gpio_in_clk(stb[0]),
    .o_gpio_in(w0[0]), .o_gpio_in_n(w0[1]), .o_gpio_in_ne(w0[2]), .o_gpio_in_e(w0[3]),
    .o_gpio_in_se(w0[4]), .o_gpio_in_s(w0[5]), .o_gpio_in_sw(w0[6]), .o_gpio_in_w(w0[7]),
    .o_gpio_in_nw(w0[8]), .o_gen(gen0), .o_overrun(ovr[0]), .o_timeout(tmo[0])
  );

  servant_gpio_xchg #(.NBR_MASK(8'h0F), .TIMEOUT(1000), .GEN_W(16)) u_dut_m (
    .i_wb_clk(clk), .i_wb_rst_n(rst_n), .i_local_clk(local_clk), .i_local_dat(local_dat),
    .i_nbr_clk(nbr_clk), .i_nbr_dat(nbr_dat), .i_hold(hold), .o_gpio_in_clk(stb[1]),
    .o_gpio_in(w1[0]), .o_gpio_in_n(w1[1]), .o_gpio_in_ne(w1[2]), .o_gpio_in_e(w1[3]),
    .o_gpio_in_se(w1[4]), .o_gpio_in_s(w1[5]), .o_gpio_in_sw(w1[6]), .o_gpio_in_w(w1[7]),
    .o_gpio_in_nw(w1[8]), .o_gen(gen1), .o_overrun(ovr[1]), .o_timeout(tmo[1])
  );

  servant_gpio_xchg #(.NBR_MASK(8'hFF), .TIMEOUT(20), .GEN_W(16)) u_dut_t (
    .i_wb_clk(clk), .i_wb_rst_n(rst_n), .i_local_clk(local_clk), .i_local_dat(local_dat),
    .i_nbr_clk(nbr_clk), .i_nbr_dat(nbr_dat), .i_hold(hold), .o_gpio_in_clk(stb[2]),
    .o_gpio_in(w2[0]), .o_gpio_in_n(w2[1]), .o_gpio_in_ne(w2[2]), .o_gpio_in_e(w2[3]),
    .o_gpio_in_se(w2[4]), .o_gpio_in_s(w2[5]), .o_gpio_in_sw(w2[6]), .o_gpio_in_w(w2[7]),
    .o_gpio_in_nw(w2[8]), .o_gen(gen2), .o_overrun(ovr[2]), .o_timeout(tmo[2])
  );

  // Pulse counter and back-to-back detector for the full-mesh instance.
  always @(negedge clk) begin
    if (stb[0]) begin
      pulses <= pulses + 1;
      if (prev_stb) dbl <= dbl + 1;
    end
    prev_stb <= stb[0];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    local_clk = 1'b0;
    nbr_clk   = '0;
  endtask

  task automatic do_reset();
    quiet();
    hold  = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Strobe local word plus the neighbours selected by mask, slot k carrying base+k, for one cycle.
  task automatic publish(input logic loc, input logic [31:0] ldat, input logic [7:0] mask,
                         input logic [31:0] base);
    local_clk = loc;
    local_dat = ldat;
    nbr_clk   = mask;
    for (int k = 0; k < 8; k++) if (mask[k]) nbr_dat[32*k +: 32] = base + 32'(k);
    tick();
    quiet();
  endtask

  int p0;
  int n;

  initial begin
    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_stb", {31'd0, stb[0]}, 32'd0);
    check("rst_gen", {16'd0, gen0}, 32'd0);
    check("rst_centre", w0[0], 32'd0);
    check("rst_ovr", {31'd0, ovr[0]}, 32'd0);

    // 1: neighbours strobed one per cycle, local with N
    tick();
    for (int k = 0; k < 8; k++) begin
      local_clk = (k == 0);
      local_dat = 32'h1;
      nbr_clk   = 8'b1 << k;
      nbr_dat[32*k +: 32] = 32'h10 + 32'(k);
      tick();
    end
    quiet();
    p0 = pulses;
    @(negedge clk);
    check("t1_no_early_stb", {31'd0, stb[0]}, 32'd0);
    tick();
    @(negedge clk);
    check("t1_stb_t2", {31'd0, stb[0]}, 32'd1);
    check("t1_centre", w0[0], 32'h1);
    check("t1_n", w0[1], 32'h10);
    check("t1_nw", w0[8], 32'h17);
    tick();
    tick();
    check("t1_pulses", 32'(pulses - p0), 32'd1);
    check("t1_gen", {16'd0, gen0}, 32'd1);

    // 2: partial mask instance, masked slots strobed but delivered as 0
    do_reset();
    nbr_dat = {8{32'h55}};
    publish(1'b1, 32'h2, 8'hFF, 32'h20);
    tick();
    @(negedge clk);
    check("t2_stb", {31'd0, stb[1]}, 32'd1);
    check("t2_se", w1[4], 32'h23);
    check("t2_s", w1[5], 32'd0);
    check("t2_nw", w1[8], 32'd0);
    tick();
    tick();

    // 3: hold for 5 cycles at DELIVER
    do_reset();
    hold = 1'b1;
    p0 = pulses;
    publish(1'b1, 32'h3, 8'hFF, 32'h30);
    nbr_dat = '1;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_held", {31'd0, stb[0]}, 32'd0);
      tick();
    end
    hold = 1'b0;
    @(negedge clk);
    check("t3_stb", {31'd0, stb[0]}, 32'd1);
    check("t3_e", w0[3], 32'h32);
    tick();
    @(negedge clk);
    check("t3_single", {31'd0, stb[0]}, 32'd0);
    tick();
    check("t3_pulses", 32'(pulses - p0), 32'd1);

    // 4: N strobed twice before delivery
    publish(1'b1, 32'h4, 8'h01, 32'hA);
    publish(1'b0, 32'h4, 8'h01, 32'hB);
    publish(1'b0, 32'h4, 8'hFE, 32'h40);
    tick();
    @(negedge clk);
    check("t4_stb", {31'd0, stb[0]}, 32'd1);
    check("t4_n", w0[1], 32'hA);
    check("t4_ne", w0[2], 32'h41);
    check("t4_ovr", {31'd0, ovr[0]}, 32'd1);
    tick();
    tick();
    check("t4_gen", {16'd0, gen0}, 32'd2);

    // 5: reset mid-COLLECT with N..SE captured
    publish(1'b1, 32'h5, 8'h0F, 32'h50);
    tick();
    @(negedge clk);
    check("t5_collect", {31'd0, stb[0]}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("t5_rst_gen", {16'd0, gen0}, 32'd0);
    check("t5_rst_ovr", {31'd0, ovr[0]}, 32'd0);
    check("t5_rst_n", w0[1], 32'd0);
    check("t5_rst_centre", w0[0], 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    p0 = pulses;
    publish(1'b1, 32'h6, 8'hF0, 32'h60);
    repeat (6) tick();
    check("t5_waits", 32'(pulses - p0), 32'd0);
    publish(1'b0, 32'h6, 8'h0F, 32'h60);
    tick();
    @(negedge clk);
    check("t5_stb", {31'd0, stb[0]}, 32'd1);
    check("t5_n", w0[1], 32'h60);
    check("t5_nw", w0[8], 32'h67);
    tick();
    tick();
    check("t5_gen", {16'd0, gen0}, 32'd1);

`ifdef SERVANT_XCHG_TIMEOUT_EN
    // 6: E never strobes in the second generation
    do_reset();
    publish(1'b1, 32'h7, 8'hFF, 32'h70);
    repeat (4) tick();
    check("t6_gen1", {16'd0, gen2}, 32'd1);
    check("t6_no_tmo", {31'd0, tmo[2]}, 32'd0);
    publish(1'b1, 32'h8, 8'hFB, 32'h80);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (stb[2]) break;
      tick();
      n++;
    end
    check("t6_delay", 32'(n), 32'd21);
    check("t6_e_prev", w2[3], 32'h72);
    check("t6_n", w2[1], 32'h80);
    check("t6_tmo", {31'd0, tmo[2]}, 32'd1);
    tick();
`else
    n = 0;
`endif

    tick();
    check("no_double_pulse", 32'(dbl), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
